// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
package mc_pkg;

    // 4-bit state encoding; 13..15 are unused and recover to S_RESET.
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12
    } state_e;

    // Opcodes from IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Bundle of datapath strobes decoded from the current state
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    // States that hold for the memory latency
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait counter: cleared on entry to a memory state, counts up and
// flags the last cycle of a MEM_LAT-cycle access.
module mc_mem_wait
    import mc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == CW'(MEM_LAT - 1));

    // Clear on entry; otherwise count, holding once the last cycle is reached
    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (!done)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle datapath: sequences fetch/decode/
// execute/writeback and drives every datapath strobe as a Moore output.
module mc_main_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    // lw/sw share MEMADR; remember which one DECODE saw, since opcode is
    // only trusted in DECODE.
    logic   is_sw_q, is_sw_d;
    logic   mem_start, mem_done;
    ctrl_t  ctrl;

    // Restart the wait counter whenever a memory state is freshly entered
    assign mem_start = is_mem_state(state_d) && (state_d != state_q);

    mc_mem_wait #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mem_start),
        .done  (mem_done)
    );

    // State and lw/sw flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Next-state logic; illegal_op is the only opcode-dependent output
    always_comb begin
        state_d    = state_q;
        is_sw_d    = is_sw_q;
        illegal_op = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW:    begin state_d = S_MEMADR; is_sw_d = 1'b0; end
                    OP_SW:    begin state_d = S_MEMADR; is_sw_d = 1'b1; end
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_ADDIEX;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_done) state_d = S_MEMWB;
            S_MEMWR:  if (mem_done) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                      state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    // Moore output decode; FETCH commits IR and PC only on its last cycle
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.ir_write  = mem_done;
                ctrl.pc_write  = mem_done;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: stimulus pushes the expected per-cycle
// output vector, a monitor pops and compares on every falling edge.
module tb_mc_main_ctrl;
    import mc_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, mrd, mwr, irw, rdst, m2r, rw, srca;
        logic [1:0] srcb, aluop, pcs;
        logic       pcw, pcwc, ill;
    } exp_t;

    // Plan codes: real state numbers plus two pseudo codes
    localparam int R   = 0,  F   = 1,  D   = 2,  MA  = 3,  MR = 4,  MWB = 5;
    localparam int MW  = 6,  EX  = 7,  AWB = 8,  AI  = 9,  AIW = 10;
    localparam int BR  = 11, JP  = 12;
    localparam int FW  = 90;   // FETCH, not its last cycle
    localparam int DI  = 91;   // DECODE with an illegal opcode

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1 = 1'b0, rst3 = 1'b0;
    logic [5:0] op1 = '0, op3 = '0;
    logic       sel = 1'b0;

    logic       iord1, mrd1, mwr1, irw1, rdst1, m2r1, rw1, srca1, pcw1, pcwc1, ill1;
    logic [1:0] srcb1, aluop1, pcs1;
    logic [3:0] st1;
    logic       iord3, mrd3, mwr3, irw3, rdst3, m2r3, rw3, srca3, pcw3, pcwc3, ill3;
    logic [1:0] srcb3, aluop3, pcs3;
    logic [3:0] st3;

    mc_main_ctrl #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst1), .opcode(op1),
        .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1), .IRWrite(irw1),
        .RegDst(rdst1), .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(srca1),
        .ALUSrcB(srcb1), .ALUOp(aluop1), .PCSource(pcs1), .PCWrite(pcw1),
        .PCWriteCond(pcwc1), .illegal_op(ill1), .state_o(st1)
    );

    mc_main_ctrl #(.MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst3), .opcode(op3),
        .IorD(iord3), .MemRead(mrd3), .MemWrite(mwr3), .IRWrite(irw3),
        .RegDst(rdst3), .MemtoReg(m2r3), .RegWrite(rw3), .ALUSrcA(srca3),
        .ALUSrcB(srcb3), .ALUOp(aluop3), .PCSource(pcs3), .PCWrite(pcw3),
        .PCWriteCond(pcwc3), .illegal_op(ill3), .state_o(st3)
    );

    exp_t act1, act3;
    assign act1 = {st1, iord1, mrd1, mwr1, irw1, rdst1, m2r1, rw1, srca1,
                   srcb1, aluop1, pcs1, pcw1, pcwc1, ill1};
    assign act3 = {st3, iord3, mrd3, mwr3, irw3, rdst3, m2r3, rw3, srca3,
                   srcb3, aluop3, pcs3, pcw3, pcwc3, ill3};

    exp_t expq[$];
    int   tagq[$];
    int   plan[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected outputs per plan code, straight from the state output table
    function automatic exp_t mk(input int c);
        exp_t e = '0;
        case (c)
            R:   e.st = 4'd0;
            FW:  begin e.st = 4'd1; e.mrd = 1; e.srcb = 2'b01; end
            F:   begin e.st = 4'd1; e.mrd = 1; e.srcb = 2'b01; e.irw = 1; e.pcw = 1; end
            D:   begin e.st = 4'd2; e.srcb = 2'b11; end
            DI:  begin e.st = 4'd2; e.srcb = 2'b11; e.ill = 1; end
            MA:  begin e.st = 4'd3; e.srca = 1; e.srcb = 2'b10; end
            MR:  begin e.st = 4'd4; e.iord = 1; e.mrd = 1; end
            MWB: begin e.st = 4'd5; e.m2r = 1; e.rw = 1; end
            MW:  begin e.st = 4'd6; e.iord = 1; e.mwr = 1; end
            EX:  begin e.st = 4'd7; e.srca = 1; e.aluop = 2'b10; end
            AWB: begin e.st = 4'd8; e.rdst = 1; e.rw = 1; end
            AI:  begin e.st = 4'd9; e.srca = 1; e.srcb = 2'b10; end
            AIW: begin e.st = 4'd10; e.rw = 1; end
            BR:  begin e.st = 4'd11; e.srca = 1; e.aluop = 2'b01; e.pcs = 2'b01; e.pcwc = 1; end
            JP:  begin e.st = 4'd12; e.pcs = 2'b10; e.pcw = 1; end
            default: e = '1;
        endcase
        return e;
    endfunction

    // One cycle: drive inputs just after the edge and queue the expectation
    task automatic step(input logic [5:0] op, input logic rst, input int c);
        @(posedge clk);
        #1;
        if (!sel) begin rst1 = rst; op1 = op; end
        else      begin rst3 = rst; op3 = op; end
        expq.push_back(mk(c));
        tagq.push_back(c);
    endtask

    // Opcode is only meaningful in DECODE; drive its complement elsewhere
    task automatic run_plan(input logic [5:0] op);
        foreach (plan[i])
            step((plan[i] == D || plan[i] == DI) ? op : ~op, 1'b1, plan[i]);
    endtask

    // Monitor: compare the selected DUT whenever an expectation is pending
    initial begin
        exp_t e, a;
        int   t;
        int   cyc = 0;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                t = tagq.pop_front();
                a = sel ? act3 : act1;
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL chk%0d lat%0d code%0d: got %h want %h",
                             cyc, sel ? 3 : 1, t, a, e);
                end
                cyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // MEM_LAT=1: reset state, release
        step(6'd0, 1'b0, R);
        step(6'd0, 1'b0, R);
        step(6'd0, 1'b1, R);
        plan = '{F, D, EX, AWB};      run_plan(OP_RTYPE);
        plan = '{F, D, MA, MR, MWB};  run_plan(OP_LW);
        plan = '{F, D, MA, MW};       run_plan(OP_SW);
        plan = '{F, D, BR};           run_plan(OP_BEQ);
        plan = '{F, D, JP};           run_plan(OP_J);
        plan = '{F, D, AI, AIW};      run_plan(OP_ADDI);
        plan = '{F, DI};              run_plan(6'b111111);
        plan = '{F, DI};              run_plan(6'b010101);
        plan = '{F, D};               run_plan(OP_RTYPE);
        // Reset asserted inside the EXEC cycle must clear outputs at once
        step(6'b111111, 1'b0, R);
        step(6'd0, 1'b1, R);
        plan = '{F, D, MA, MW};       run_plan(OP_SW);
        plan = '{F};                  run_plan(OP_J);

        // MEM_LAT=3 instance
        @(posedge clk); #1;
        sel = 1'b1;
        step(6'd0, 1'b0, R);
        step(6'd0, 1'b1, R);
        plan = '{FW, FW, F, D, MA, MR, MR, MR, MWB};  run_plan(OP_LW);
        plan = '{FW, FW, F, D, MA, MW, MW, MW};       run_plan(OP_SW);
        plan = '{FW, FW, F, D, BR};                   run_plan(OP_BEQ);
        plan = '{FW, FW, F};                          run_plan(OP_ADDI);

        repeat (2) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
